// File: rtl/ball_motion.sv
// Ball position generator for breakout: rides the paddle until served, then steps per tick.
// Latency: one cycle; position, direction and bounce are registered and visible after the tick edge.
// Backpressure: none; motion is paced by tick_i and stopped only by game_over_i or reset.
//
// Ports:
//   clk_i        game clock (difficulty-scaled)
//   reset_i      asynchronous reset, active low
//   tick_i       move enable, single-cycle pulse
//   launch_i     serve request; only honoured while the ball rides the paddle
//   paddle_x_i   paddle centre x
//   brick_hit_i  brick collision on this tick; flips the vertical direction
//   game_over_i  freezes the ball until the next reset
//   ball_x_o     ball centre x
//   ball_y_o     ball centre y
//   dx_neg_o     1 = moving left
//   dy_neg_o     1 = moving up
//   bounce_o     single-cycle pulse after a tick that reflected the ball
//
// Optional feature macro: BALL_SPIN_EN
//   defined   -> a paddle hit also sets horizontal speed (outer quarter 2*STEP, centre STEP)
//                and horizontal direction (left of paddle centre = moving left)
//   undefined -> horizontal speed fixed at STEP; a paddle hit flips the vertical direction only
module ball_motion #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int BALL_R   = 3,
  parameter int PADDLE_Y = 440,
  parameter int PADDLE_W = 40,
  parameter int START_X  = 320,
  parameter int STEP     = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       launch_i,
  input  logic [9:0] paddle_x_i,
  input  logic       brick_hit_i,
  input  logic       game_over_i,
  output logic [9:0] ball_x_o,
  output logic [8:0] ball_y_o,
  output logic       dx_neg_o,
  output logic       dy_neg_o,
  output logic       bounce_o
);

  // Playfield limits for the ball centre, in the signed 11-bit domain used for next-position maths.
  localparam logic signed [10:0] X_MIN   = 11'(BALL_R);
  localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - 1 - BALL_R);
  localparam logic signed [10:0] Y_MIN   = 11'(BALL_R);
  localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - 1 - BALL_R);
  localparam logic signed [10:0] Y_PAD   = 11'(PADDLE_Y - BALL_R);
  localparam logic signed [10:0] HALF_W  = 11'(PADDLE_W / 2);
  localparam logic signed [10:0] STEP_S  = 11'(STEP);

  localparam logic [9:0] SERVE_X_MIN = 10'(BALL_R);
  localparam logic [9:0] SERVE_X_MAX = 10'(SCREEN_W - 1 - BALL_R);
  localparam logic [9:0] RST_X       = 10'(START_X);
  // Resting row on the paddle: one pixel above the paddle contact line.
  localparam logic [8:0] RST_Y       = 9'(PADDLE_Y - BALL_R - 1);

  localparam logic [3:0] SPD_1 = 4'(STEP);
`ifdef BALL_SPIN_EN
  localparam logic [3:0]         SPD_2 = 4'(2 * STEP);
  localparam logic signed [10:0] QTR_W = 11'(PADDLE_W / 4);
`endif

  typedef enum logic [1:0] {
    S_SERVE  = 2'd0,
    S_MOVING = 2'd1,
    S_FROZEN = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       dx_neg_q, dx_neg_d;
  logic       dy_neg_q, dy_neg_d;
  logic       bounce_q, bounce_d;
  logic [3:0] spd_q, spd_d;   // horizontal speed; constant STEP unless spin is built in

  // ---------------------------------------------------------------------------
  // Next-position arithmetic. Everything is widened to signed 11 bits so a step
  // past the left or top edge goes negative instead of wrapping to a large value.
  // ---------------------------------------------------------------------------
  logic signed [10:0] x_s, y_s, px_s, spd_s;
  logic signed [10:0] nx, ny;
  logic signed [10:0] off, off_abs;
  logic               hit_left, hit_right, hit_top, hit_pad;
  logic [9:0]         serve_x;

  assign x_s   = {1'b0, x_q};
  assign y_s   = {2'b00, y_q};
  assign px_s  = {1'b0, paddle_x_i};
  assign spd_s = {7'b0, spd_q};

  assign nx = dx_neg_q ? (x_s - spd_s) : (x_s + spd_s);
  assign ny = dy_neg_q ? (y_s - STEP_S) : (y_s + STEP_S);

  // Offset of the ball from the paddle centre, measured at the current position.
  assign off     = x_s - px_s;
  assign off_abs = off[10] ? -off : off;

  assign hit_left  = (nx <= X_MIN);
  assign hit_right = (nx >= X_MAX);
  assign hit_top   = (ny <= Y_MIN);
  // Paddle catch only when falling and crossing the contact line on this tick,
  // so a ball already below the line keeps falling even if the paddle moves under it.
  assign hit_pad   = !dy_neg_q && (y_s < Y_PAD) && (ny >= Y_PAD) && (off_abs <= HALF_W);

  // While serving the ball follows the paddle, kept fully on screen.
  always_comb begin
    serve_x = paddle_x_i;
    if (paddle_x_i < SERVE_X_MIN) begin
      serve_x = SERVE_X_MIN;
    end else if (paddle_x_i > SERVE_X_MAX) begin
      serve_x = SERVE_X_MAX;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_SERVE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. game over wins over everything; FROZEN is left only by reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (game_over_i) begin
      state_d = S_FROZEN;
    end else begin
      unique case (state_q)
        S_SERVE:  if (launch_i) state_d = S_MOVING;
        S_MOVING: state_d = S_MOVING;
        S_FROZEN: state_d = S_FROZEN;
        default:  state_d = S_SERVE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (next values of the position/direction registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    spd_d    = spd_q;
    bounce_d = 1'b0;

    if (!game_over_i) begin
      unique case (state_q)
        S_SERVE: begin
          x_d   = serve_x;
          spd_d = SPD_1;
          if (launch_i) begin
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b1;
          end
        end

        S_MOVING: begin
          if (tick_i) begin
            // Horizontal: clamp to the wall and point away from it.
            if (hit_left) begin
              x_d      = 10'(X_MIN);
              dx_neg_d = 1'b0;
            end else if (hit_right) begin
              x_d      = 10'(X_MAX);
              dx_neg_d = 1'b1;
            end else begin
              x_d = 10'(nx);
            end

            // Vertical: top wall and paddle force a direction, so a brick hit on
            // the same tick does not flip a second time. Below the paddle the ball
            // sinks until it rests at the bottom limit.
            if (hit_top) begin
              y_d      = 9'(Y_MIN);
              dy_neg_d = 1'b0;
            end else if (hit_pad) begin
              y_d      = RST_Y;
              dy_neg_d = 1'b1;
            end else begin
              y_d = (ny >= Y_MAX) ? 9'(Y_MAX) : 9'(ny);
              if (brick_hit_i) begin
                dy_neg_d = !dy_neg_q;
              end
            end

`ifdef BALL_SPIN_EN
            // English off the paddle. A wall reflection on the same tick keeps
            // its direction so the ball never heads back into the wall.
            if (hit_pad) begin
              spd_d = (off_abs > QTR_W) ? SPD_2 : SPD_1;
              if (!hit_left && !hit_right) begin
                dx_neg_d = off[10];
              end
            end
`endif

            bounce_d = hit_left | hit_right | hit_top | hit_pad | brick_hit_i;
          end
        end

        S_FROZEN: begin
          // hold everything
        end

        default: begin
          // unreachable encoding: hold
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Position / direction registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      x_q      <= RST_X;
      y_q      <= RST_Y;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b1;
      bounce_q <= 1'b0;
      spd_q    <= SPD_1;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      dx_neg_q <= dx_neg_d;
      dy_neg_q <= dy_neg_d;
      bounce_q <= bounce_d;
      spd_q    <= spd_d;
    end
  end

  assign ball_x_o = x_q;
  assign ball_y_o = y_q;
  assign dx_neg_o = dx_neg_q;
  assign dy_neg_o = dy_neg_q;
  assign bounce_o = bounce_q;

endmodule

// File: tb/tb_ball_motion.sv
module tb_ball_motion;

  // Playfield facts for the default parameter set.
  localparam int X_L     = 3;
  localparam int X_R     = 636;
  localparam int Y_T     = 3;
  localparam int Y_SERVE = 436;
  localparam int Y_PAD   = 437;
  localparam int Y_BOT   = 476;
  localparam int HALF    = 20;
  localparam int START   = 320;

  localparam int M_SERVE  = 0;
  localparam int M_MOVE   = 1;
  localparam int M_FROZEN = 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick    = 1'b0;
  logic       launch  = 1'b0;
  logic       brick   = 1'b0;
  logic       go      = 1'b0;
  logic [9:0] px      = 10'd0;
  logic [9:0] bx;
  logic [8:0] by;
  logic       dxn, dyn, bnc;

  ball_motion dut (
    .clk_i       (clk),
    .reset_i     (reset_n),
    .tick_i      (tick),
    .launch_i    (launch),
    .paddle_x_i  (px),
    .brick_hit_i (brick),
    .game_over_i (go),
    .ball_x_o    (bx),
    .ball_y_o    (by),
    .dx_neg_o    (dxn),
    .dy_neg_o    (dyn),
    .bounce_o    (bnc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers following the game rules.
  int m_mode, m_x, m_y, m_spd;
  bit m_dxn, m_dyn, m_b;

  typedef struct {
    bit t, l, b, g;
    int p;
    int ex, ey;
    bit edx, edy, eb;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(bit t, bit l, bit b, bit g, int p,
                              int ex, int ey, bit edx, bit edy, bit eb);
    vec_t v;
    v.t = t; v.l = l; v.b = b; v.g = g; v.p = p;
    v.ex = ex; v.ey = ey; v.edx = edx; v.edy = edy; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    logic [21:0] act, exp;
    act = {bx, by, dxn, dyn, bnc};
    exp = {10'(m_x), 9'(m_y), m_dxn, m_dyn, m_b};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d dxn=%0b dyn=%0b b=%0b, model x=%0d y=%0d dxn=%0b dyn=%0b b=%0b",
               name, bx, by, dxn, dyn, bnc, m_x, m_y, m_dxn, m_dyn, m_b);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SERVE;
    m_x    = START;
    m_y    = Y_SERVE;
    m_dxn  = 1'b0;
    m_dyn  = 1'b1;
    m_b    = 1'b0;
    m_spd  = 1;
  endtask

  // One game-clock edge of the reference, given the inputs sampled at that edge.
  task automatic model_clock(input bit t, input bit l, input bit br, input bit g, input int p);
    int nx, ny, off;
    bit xr, top, pad;
    m_b = 1'b0;
    if (g) begin
      m_mode = M_FROZEN;
    end else if (m_mode == M_SERVE) begin
      m_x   = (p < X_L) ? X_L : ((p > X_R) ? X_R : p);
      m_spd = 1;
      if (l) begin
        m_mode = M_MOVE;
        m_dxn  = 1'b0;
        m_dyn  = 1'b1;
      end
    end else if (m_mode == M_MOVE && t) begin
      nx  = m_dxn ? m_x - m_spd : m_x + m_spd;
      ny  = m_dyn ? m_y - 1 : m_y + 1;
      off = m_x - p;
      top = (ny <= Y_T);
      pad = !m_dyn && (m_y < Y_PAD) && (ny >= Y_PAD) && (off <= HALF) && (off >= -HALF);
      xr  = 1'b0;
      if (nx <= X_L) begin
        nx = X_L; m_dxn = 1'b0; xr = 1'b1;
      end else if (nx >= X_R) begin
        nx = X_R; m_dxn = 1'b1; xr = 1'b1;
      end
      if (top) begin
        ny = Y_T; m_dyn = 1'b0;
      end else if (pad) begin
        ny = Y_SERVE; m_dyn = 1'b1;
      end else begin
        if (ny > Y_BOT) ny = Y_BOT;
        if (br) m_dyn = !m_dyn;
      end
`ifdef BALL_SPIN_EN
      if (pad) begin
        m_spd = ((off > 10) || (off < -10)) ? 2 : 1;
        if (!xr) m_dxn = (off < 0);
      end
`endif
      m_x = nx;
      m_y = ny;
      m_b = xr || top || pad || br;
    end
  endtask

  // Advance one clock: inputs are held across the edge, outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    model_clock(tick, launch, brick, go, int'(px));
    #1;
  endtask

  task automatic do_reset(input int p);
    reset_n = 1'b0;
    tick = 1'b0; launch = 1'b0; brick = 1'b0; go = 1'b0;
    px = 10'(p);
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1; launch = 1'b0; brick = 1'b0; go = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk_model("run");
    end
    tick = 1'b0;
  endtask

  // Tick until the model shows the ball on the paddle row heading down.
  task automatic wait_falling_at_paddle(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (m_y == Y_SERVE && !m_dyn) found = 1'b1;
      else run_ticks(1);
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int q;

    // ---------------- reset state ----------------
    do_reset(100);
    chk("rst_x", bx, START);
    chk("rst_y", by, Y_SERVE);
    chk("rst_dxn", dxn, 0);
    chk("rst_dyn", dyn, 1);
    chk("rst_bounce", bnc, 0);

    // ---------------- table: serve, launch, first moves ----------------
    //              t  l  b  g  px    x    y   dx dy  b
    tbl[0]  = mk(0, 0, 0, 0, 100,  100, 436, 0, 1, 0);
    tbl[1]  = mk(1, 0, 0, 0, 100,  100, 436, 0, 1, 0);  // tick while serving: no motion
    tbl[2]  = mk(0, 0, 0, 0, 1,    3,   436, 0, 1, 0);  // clamp left
    tbl[3]  = mk(0, 0, 0, 0, 1000, 636, 436, 0, 1, 0);  // clamp right
    tbl[4]  = mk(0, 0, 0, 0, 320,  320, 436, 0, 1, 0);
    tbl[5]  = mk(1, 1, 0, 0, 320,  320, 436, 0, 1, 0);  // launch cycle: no step yet
    tbl[6]  = mk(1, 0, 0, 0, 320,  321, 435, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 320,  321, 435, 0, 1, 0);  // no tick: hold
    tbl[8]  = mk(1, 1, 0, 0, 320,  322, 434, 0, 1, 0);  // launch ignored in flight
    tbl[9]  = mk(1, 0, 1, 0, 320,  323, 433, 0, 0, 1);  // brick flips dy
    tbl[10] = mk(0, 0, 0, 0, 320,  323, 433, 0, 0, 0);  // bounce lasts one cycle
    tbl[11] = mk(1, 0, 0, 0, 320,  324, 434, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      tick = tbl[i].t; launch = tbl[i].l; brick = tbl[i].b; go = tbl[i].g;
      px = 10'(tbl[i].p);
      step();
      chk($sformatf("vec%0d_x", i), bx, tbl[i].ex);
      chk($sformatf("vec%0d_y", i), by, tbl[i].ey);
      chk($sformatf("vec%0d_dxn", i), dxn, tbl[i].edx);
      chk($sformatf("vec%0d_dyn", i), dyn, tbl[i].edy);
      chk($sformatf("vec%0d_b", i), bnc, tbl[i].eb);
    end
    tick = 0; launch = 0; brick = 0;

    // ---------------- right wall, then top wall with brick ----------------
    do_reset(320);
    launch = 1; step(); launch = 0;
    run_ticks(315);
    chk("right_pre_x", bx, 635);
    tick = 1; step(); tick = 0;
    chk("right_x", bx, X_R);
    chk("right_dxn", dxn, 1);
    chk("right_b", bnc, 1);
    step();
    chk("right_b_clear", bnc, 0);
    run_ticks(1);
    chk("right_back_x", bx, 635);
    run_ticks(115);
    chk("top_pre_y", by, 4);
    tick = 1; brick = 1; step(); tick = 0; brick = 0;
    chk("top_brick_y", by, Y_T);
    chk("top_brick_dyn", dyn, 0);
    chk("top_brick_b", bnc, 1);
    run_ticks(1);
    chk("top_after_y", by, 4);
    chk("top_after_dyn", dyn, 0);
    chk("top_after_b", bnc, 0);

    // ---------------- paddle catch at the edge of the paddle ----------------
    wait_falling_at_paddle("wait_pad1");
    px = 10'(m_x + HALF);
    tick = 1; step(); tick = 0;
    chk_model("pad_model");
    chk("pad_y", by, Y_SERVE);
    chk("pad_dyn", dyn, 1);
    chk("pad_b", bnc, 1);

    // ---------------- one pixel outside the paddle: miss and sink ----------------
    wait_falling_at_paddle("wait_pad2");
    px = 10'(m_x + HALF + 1);
    tick = 1; step(); tick = 0;
    chk("miss_y", by, Y_PAD);
    chk("miss_dyn", dyn, 0);
    run_ticks(39);
    chk("miss_bottom_y", by, Y_BOT);
    run_ticks(5);
    chk("miss_hold_y", by, Y_BOT);
    chk("miss_hold_dyn", dyn, 0);

    // ---------------- corner: both axes reflect on one tick ----------------
    do_reset(203);
    launch = 1; step(); launch = 0;
    run_ticks(432);
    chk("corner_pre_x", bx, 635);
    chk("corner_pre_y", by, 4);
    tick = 1; step(); tick = 0;
    chk("corner_x", bx, X_R);
    chk("corner_y", by, Y_T);
    chk("corner_dxn", dxn, 1);
    chk("corner_dyn", dyn, 0);
    chk("corner_b", bnc, 1);

    // ---------------- game over beats tick/launch/bounce ----------------
    do_reset(203);
    launch = 1; step(); launch = 0;
    run_ticks(432);
    tick = 1; launch = 1; go = 1; step(); go = 0;
    chk("frz_x", bx, 635);
    chk("frz_y", by, 4);
    chk("frz_dyn", dyn, 1);
    chk("frz_b", bnc, 0);
    for (int i = 0; i < 5; i++) begin
      tick = 1; launch = 1; step();
      chk_model("frz_hold");
    end
    tick = 0; launch = 0;
    chk("frz_hold_x", bx, 635);

    // ---------------- asynchronous reset mid-flight ----------------
    do_reset(203);
    launch = 1; step(); launch = 0;
    run_ticks(10);
    chk("flight_x", bx, 213);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_x", bx, START);
    chk("arst_y", by, Y_SERVE);
    chk("arst_dyn", dyn, 1);
    chk("arst_dxn", dxn, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("arst_serve_x", bx, 203);

    // ---------------- randomized play against the model ----------------
    for (int r = 0; r < 4; r++) begin
      do_reset(int'($urandom_range(0, 1023)));
      for (int c = 0; c < 700; c++) begin
        tick   = ($urandom_range(0, 3) != 0);
        launch = ($urandom_range(0, 19) == 0);
        brick  = ($urandom_range(0, 39) == 0);
        go     = ($urandom_range(0, 1999) == 0);
        case ($urandom_range(0, 3))
          0: px = 10'($urandom_range(0, 1023));
          1, 2: begin
            q = m_x + int'($urandom_range(0, 50)) - 25;
            if (q < 0) q = 0;
            if (q > 1023) q = 1023;
            px = 10'(q);
          end
          default: ;
        endcase
        step();
        chk_model("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
